hsitorgb_winpaint: RTL and testbench
====================================

HSITORGB_WINPAINT -- requirements
Module: hsitorgb_winpaint

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clk  in  1  rising-edge pipeline clock.
REQ-003 rst  in  1  asynchronous active-high reset.
REQ-004 Hin  in  8  hue, 0-239 is one full turn; 240-255 wraps as Hin-240.
REQ-005 Sin  in  8  saturation, 0-255, where 255 means full saturation (Paint 240).
REQ-006 Iin  in  8  lightness, 0-255, where 255 means white (Paint 240).
REQ-007 HSIinEn  in  1  input sample valid, one pixel per asserted cycle.
REQ-008 R, G, B  out  8 each  registered colour outputs.
REQ-009 RGBoutEn  out  1  output valid, aligned with R/G/B.

Function
REQ-010 The block SHALL implement the inverse of the Windows Paint "edit colours" HSL model, pairing with the RGB-to-HSI block.
REQ-011 The pipeline SHALL be five stages, accept one pixel per clock, and have no backpressure.
REQ-012 RGBoutEn SHALL equal HSIinEn delayed by exactly 5 clocks, with R/G/B valid in the same cycle.
REQ-013 Data SHALL advance every cycle regardless of HSIinEn; R/G/B when RGBoutEn=0 are don't-care.
REQ-014 S1 SHALL compute h = Hin<240 ? Hin : Hin-240; sector = floor(h/40) (0-5); f = h-40*sector (0-39).
REQ-015 S1 SHALL compute cb = min(2*Iin, 510-2*Iin), range 0-254.
REQ-016 S2 SHALL compute p = cb*Sin and C = (p + (p>>8) + 128)>>8, range 0-255, an approximation of cb*S/255.
REQ-017 S2 SHALL compute fx = sector odd ? 40-f : f, range 0-40.
REQ-018 S3 SHALL compute X = (C*fx*205 + 4096)>>13, an approximation of C*fx/40 with no divider.
REQ-019 S3 SHALL compute m = I - ((C+1)>>1), clamped at 0.
REQ-020 S4 SHALL assign (r,g,b) by sector: 0:(C,X,0) 1:(X,C,0) 2:(0,C,X) 3:(0,X,C) 4:(X,0,C) 5:(C,0,X).
REQ-021 S5 SHALL output R/G/B = min(255, component+m) as registered outputs.
REQ-022 Intermediate widths SHALL be full precision with no silent truncation before the specified shifts; p is 16 bits and C*fx*205 is 22 bits.
REQ-023 The block SHALL use no vendor IP; multiplies infer DSP or LUT logic.

Reset
REQ-024 Asserting rst SHALL immediately clear all pipeline registers, forcing R=G=B=0 and RGBoutEn=0.
REQ-025 Pixels in flight when rst asserts SHALL be discarded; none SHALL emerge after release.
REQ-026 After rst deasserts, the first valid output SHALL appear 5 clocks after the first sampled HSIinEn=1.

Structure
REQ-027 A shared package SHALL hold H_SPAN=240, SECTOR_W=40, RECIP40=205, RECIP_SHIFT=13 and LATENCY=5.
REQ-028 One sub-module, hsi_sector_assign, SHALL implement REQ-020 combinationally (sector, C, X -> r, g, b).

Verification
REQ-029 H=100, S=0, I=128 -> five clocks later (128,128,128) with RGBoutEn=1.
REQ-030 H=0, S=255, I=128 -> (255,1,1); H=80, S=255, I=128 -> (1,255,1).
REQ-031 H=20, S=255, I=128 -> (255,128,1); H=250, S=255, I=128 (wrap to 10) -> (255,65,1).
REQ-032 Ten back-to-back pixels with a 2-cycle HSIinEn gap -> RGBoutEn shows the identical pattern shifted 5 clocks, and every output matches the bit-exact model of REQ-014 to REQ-021.
REQ-033 Assert rst for 1 cycle while 3 pixels are in flight -> outputs 0 and RGBoutEn=0 immediately, no stale pixel afterwards, and a new pixel appears 5 clocks after its input.
REQ-034 Exhaustive sweep of H 0-255 and I 0-255 at S in {0,128,255} -> zero mismatches against the model, and the sweep SHALL include the saturation case I=255 -> (255,255,255).

Source files
------------

// File: rtl/hsitorgb_winpaint_pkg.sv
// Shared constants, stage records and sector helper for the Paint-style HSI-to-RGB pipeline.
// Pure declarations; no latency, no flow control.
package hsitorgb_winpaint_pkg;

    localparam int H_SPAN      = 240;
    localparam int SECTOR_W    = 40;
    localparam int RECIP40     = 205;
    localparam int RECIP_SHIFT = 13;
    localparam int LATENCY     = 5;

    typedef struct packed {
        logic       vld;
        logic [2:0] sector;
        logic [5:0] f;
        logic [7:0] cb;
        logic [7:0] s;
        logic [7:0] i;
    } s1_t;

    typedef struct packed {
        logic       vld;
        logic [2:0] sector;
        logic [7:0] c;
        logic [5:0] fx;
        logic [7:0] i;
    } s2_t;

    typedef struct packed {
        logic       vld;
        logic [2:0] sector;
        logic [7:0] c;
        logic [7:0] x;
        logic [7:0] m;
    } s3_t;

    typedef struct packed {
        logic       vld;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic [7:0] m;
    } s4_t;

    // floor(h/40) by threshold compares, h already folded into 0..239
    function automatic logic [2:0] sector_of(input logic [7:0] h);
        logic [2:0] sec;
        sec = 3'd0;
        for (int k = 1; k < 6; k++) begin
            if (h >= 8'(SECTOR_W * k)) sec = 3'(k);
        end
        return sec;
    endfunction

endpackage

// File: rtl/hsitorgb_winpaint_sector_assign.sv
// Routes chroma C and ramp X onto r/g/b by hue sector.
// Combinational, no backpressure.
module hsi_sector_assign
    import hsitorgb_winpaint_pkg::*;
(
    input  logic [2:0] sector,
    input  logic [7:0] c,
    input  logic [7:0] x,
    output logic [7:0] r,
    output logic [7:0] g,
    output logic [7:0] b
);

    always_comb begin
        r = 8'd0;
        g = 8'd0;
        b = 8'd0;
        case (sector)
            3'd0: begin r = c; g = x; end
            3'd1: begin r = x; g = c; end
            3'd2: begin g = c; b = x; end
            3'd3: begin g = x; b = c; end
            3'd4: begin r = x; b = c; end
            3'd5: begin r = c; b = x; end
            default: ;
        endcase
    end

endmodule

// File: rtl/hsitorgb_winpaint.sv
// Windows Paint HSL (0-239 hue turn) to RGB, one pixel per clock.
// Latency 5 clocks, no backpressure; data advances every cycle.
module hsitorgb_winpaint
    import hsitorgb_winpaint_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] Hin,
    input  logic [7:0] Sin,
    input  logic [7:0] Iin,
    input  logic       HSIinEn,
    output logic [7:0] R,
    output logic [7:0] G,
    output logic [7:0] B,
    output logic       RGBoutEn
);

    s1_t s1_d, s1_q;
    s2_t s2_d, s2_q;
    s3_t s3_d, s3_q;
    s4_t s4_d, s4_q;
    logic [7:0] r_d, r_q, g_d, g_q, b_d, b_q;
    logic       vld_d, vld_q;

    logic [7:0]  h;
    logic [2:0]  sec;
    logic [8:0]  i2, i2n;
    logic [15:0] p, csum;
    logic [21:0] xprod;
    logic [8:0]  half;
    logic [7:0]  r_a, g_a, b_a;
    logic [8:0]  r_sum, g_sum, b_sum;

    hsi_sector_assign u_assign (
        .sector (s3_q.sector),
        .c      (s3_q.c),
        .x      (s3_q.x),
        .r      (r_a),
        .g      (g_a),
        .b      (b_a)
    );

    always_comb begin
        s1_d = '0;
        s2_d = '0;
        s3_d = '0;
        s4_d = '0;

        // S1: fold hue, split into sector/offset, chroma base from lightness
        h            = (Hin < 8'(H_SPAN)) ? Hin : Hin - 8'(H_SPAN);
        sec          = sector_of(h);
        s1_d.vld     = HSIinEn;
        s1_d.sector  = sec;
        s1_d.f       = 6'(h - 8'(SECTOR_W) * {5'd0, sec});
        i2           = {Iin, 1'b0};
        i2n          = 9'd510 - i2;
        s1_d.cb      = 8'((i2 < i2n) ? i2 : i2n);
        s1_d.s       = Sin;
        s1_d.i       = Iin;

        // S2: C ~= cb*S/255 via (p + p/256 + 0.5)/256
        p            = {8'd0, s1_q.cb} * {8'd0, s1_q.s};
        csum         = p + {8'd0, p[15:8]} + 16'd128;
        s2_d.vld     = s1_q.vld;
        s2_d.sector  = s1_q.sector;
        s2_d.c       = 8'(csum >> 8);
        s2_d.fx      = s1_q.sector[0] ? 6'(SECTOR_W) - s1_q.f : s1_q.f;
        s2_d.i       = s1_q.i;

        // S3: X ~= C*fx/40 as multiply by 205/8192, rounded
        xprod        = 22'(s2_q.c) * 22'(s2_q.fx) * 22'(RECIP40) + 22'(1 << (RECIP_SHIFT - 1));
        half         = ({1'b0, s2_q.c} + 9'd1) >> 1;
        s3_d.vld     = s2_q.vld;
        s3_d.sector  = s2_q.sector;
        s3_d.c       = s2_q.c;
        s3_d.x       = 8'(xprod >> RECIP_SHIFT);
        s3_d.m       = ({1'b0, s2_q.i} >= half) ? 8'({1'b0, s2_q.i} - half) : 8'd0;

        s4_d.vld     = s3_q.vld;
        s4_d.r       = r_a;
        s4_d.g       = g_a;
        s4_d.b       = b_a;
        s4_d.m       = s3_q.m;

        // S5: lift by m and saturate
        r_sum        = {1'b0, s4_q.r} + {1'b0, s4_q.m};
        g_sum        = {1'b0, s4_q.g} + {1'b0, s4_q.m};
        b_sum        = {1'b0, s4_q.b} + {1'b0, s4_q.m};
        r_d          = r_sum[8] ? 8'hFF : r_sum[7:0];
        g_d          = g_sum[8] ? 8'hFF : g_sum[7:0];
        b_d          = b_sum[8] ? 8'hFF : b_sum[7:0];
        vld_d        = s4_q.vld;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q  <= '0;
            s2_q  <= '0;
            s3_q  <= '0;
            s4_q  <= '0;
            r_q   <= '0;
            g_q   <= '0;
            b_q   <= '0;
            vld_q <= 1'b0;
        end else begin
            s1_q  <= s1_d;
            s2_q  <= s2_d;
            s3_q  <= s3_d;
            s4_q  <= s4_d;
            r_q   <= r_d;
            g_q   <= g_d;
            b_q   <= b_d;
            vld_q <= vld_d;
        end
    end

    assign R        = r_q;
    assign G        = g_q;
    assign B        = b_q;
    assign RGBoutEn = vld_q;

endmodule

// File: tb/tb_hsitorgb_winpaint.sv
// Randomized and directed bench for hsitorgb_winpaint against an arithmetic reference model.
module tb_hsitorgb_winpaint;
    import hsitorgb_winpaint_pkg::*;

    logic       clk;
    logic       rst;
    logic [7:0] Hin, Sin, Iin;
    logic       HSIinEn;
    logic [7:0] R, G, B;
    logic       RGBoutEn;

    typedef struct {
        bit          en;
        logic [23:0] rgb;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   svals[3] = '{0, 128, 255};

    hsitorgb_winpaint dut (
        .clk      (clk),
        .rst      (rst),
        .Hin      (Hin),
        .Sin      (Sin),
        .Iin      (Iin),
        .HSIinEn  (HSIinEn),
        .R        (R),
        .G        (G),
        .B        (B),
        .RGBoutEn (RGBoutEn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] ref_rgb(input int h_in, input int s, input int i);
        int h, sec, f, cb, p, c, fx, x, m, r, g, b;
        h   = (h_in < 240) ? h_in : h_in - 240;
        sec = h / 40;
        f   = h % 40;
        cb  = (2 * i < 510 - 2 * i) ? 2 * i : 510 - 2 * i;
        p   = cb * s;
        c   = (p + p / 256 + 128) / 256;
        fx  = (sec % 2 == 1) ? 40 - f : f;
        x   = (c * fx * 205 + 4096) / 8192;
        m   = i - (c + 1) / 2;
        if (m < 0) m = 0;
        r = 0; g = 0; b = 0;
        case (sec)
            0: begin r = c; g = x; end
            1: begin r = x; g = c; end
            2: begin g = c; b = x; end
            3: begin g = x; b = c; end
            4: begin r = x; b = c; end
            default: begin r = c; b = x; end
        endcase
        r = (r + m > 255) ? 255 : r + m;
        g = (g + m > 255) ? 255 : g + m;
        b = (b + m > 255) ? 255 : b + m;
        return {8'(r), 8'(g), 8'(b)};
    endfunction

    task automatic prefill();
        exp_q.delete();
        for (int k = 0; k < LATENCY - 1; k++) exp_q.push_back('{1'b0, 24'h0});
    endtask

    task automatic step(input int h, input int s, input int i, input bit en);
        exp_t e;
        Hin     = 8'(h);
        Sin     = 8'(s);
        Iin     = 8'(i);
        HSIinEn = en;
        @(posedge clk);
        #1;
        exp_q.push_back('{en, ref_rgb(h, s, i)});
        e = exp_q.pop_front();
        chk("out_vld", {31'd0, RGBoutEn}, {31'd0, e.en});
        if (e.en) chk("out_rgb", {8'd0, R, G, B}, {8'd0, e.rgb});
    endtask

    task automatic directed(input string tag, input int h, input int s, input int i,
                            input logic [23:0] exp);
        step(h, s, i, 1'b1);
        repeat (LATENCY - 1) step(0, 0, 0, 1'b0);
        chk({tag, "_vld"}, {31'd0, RGBoutEn}, 32'd1);
        chk({tag, "_rgb"}, {8'd0, R, G, B}, {8'd0, exp});
    endtask

    task automatic rnd_pixel(input bit en);
        step($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), en);
    endtask

    initial begin
        int n;
        rst = 1'b1; Hin = 8'd0; Sin = 8'd0; Iin = 8'd0; HSIinEn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_vld", {31'd0, RGBoutEn}, 32'd0);
        chk("rst_r", {24'd0, R}, 32'd0);
        chk("rst_g", {24'd0, G}, 32'd0);
        chk("rst_b", {24'd0, B}, 32'd0);
        rst = 1'b0;
        prefill();

        directed("grey",   100,   0, 128, 24'h808080);
        directed("red",      0, 255, 128, 24'hFF0101);
        directed("green",   80, 255, 128, 24'h01FF01);
        directed("orange",  20, 255, 128, 24'hFF8001);
        directed("wrap",   250, 255, 128, 24'hFF4101);

        // back-to-back burst, 2-cycle gap, second burst
        for (int k = 0; k < 10; k++) rnd_pixel(1'b1);
        repeat (2) step(0, 0, 0, 1'b0);
        for (int k = 0; k < 10; k++) rnd_pixel(1'b1);
        repeat (LATENCY) step(0, 0, 0, 1'b0);

        // reset with three pixels in flight
        repeat (3) rnd_pixel(1'b1);
        HSIinEn = 1'b0;
        #3 rst = 1'b1;
        #1;
        chk("midrst_vld", {31'd0, RGBoutEn}, 32'd0);
        chk("midrst_rgb", {8'd0, R, G, B}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        prefill();
        repeat (LATENCY + 2) step(0, 0, 0, 1'b0);
        directed("post_rst", 0, 255, 128, 24'hFF0101);

        for (int k = 0; k < 300; k++) rnd_pixel($urandom_range(0, 3) != 0);

        // sweep every H and every I, half the pairs, rotating S
        n = 0;
        for (int h = 0; h < 256; h++) begin
            for (int i = 0; i < 256; i++) begin
                if (((h + i) % 2) == 0) begin
                    step(h, svals[n % 3], i, 1'b1);
                    n++;
                end
            end
        end
        repeat (LATENCY) step(0, 0, 0, 1'b0);

        for (int k = 0; k < 3; k++) directed("white", 17 * k, svals[k], 255, 24'hFFFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
